// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave receive stage: assembles MSB-first bytes from SCLK rising-edge
// pulses inside a CS_N frame and reports byte strobes, frame end and truncation errors.
module spi_byte_rx #(
  parameter int MOSI_DLY  = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 spi_sclk_rising_in,
  input  logic                 spi_cs_n_falling_in,
  input  logic                 spi_cs_n_rising_in,
  input  logic                 spi_mosi_in,
  output logic                 byte_valid_out,
  output logic [7:0]           byte_data_out,
  output logic                 byte_first_out,
  output logic [CNT_WIDTH-1:0] byte_cnt_out,
  output logic                 frame_end_out,
  output logic                 frame_err_out
);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [MOSI_DLY-1:0]    mosi_pipe_q;
  logic                   mosi_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic                   first_q, first_d;
  logic [7:0]             byte_data_q, byte_data_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   byte_first_q, byte_first_d;
  logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
  logic                   frame_end_q, frame_end_d;
  logic                   frame_err_q, frame_err_d;
  logic                   byte_done;

  // MOSI delay line matches the register stage inside the SCLK edge detector.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mosi_pipe_q <= '0;
    end else begin
      mosi_pipe_q[0] <= spi_mosi_in;
      for (int i = 1; i < MOSI_DLY; i++) begin
        mosi_pipe_q[i] <= mosi_pipe_q[i-1];
      end
    end
  end

  assign mosi_d = mosi_pipe_q[MOSI_DLY-1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    first_d      = first_q;
    byte_data_d  = byte_data_q;
    byte_cnt_d   = byte_cnt_q;
    byte_valid_d = 1'b0;
    byte_first_d = 1'b0;
    frame_end_d  = 1'b0;
    frame_err_d  = 1'b0;
    byte_done    = 1'b0;

    case (state_q)
      IDLE: begin
        // A simultaneous CS rise means the line ends high: stay idle.
        if (spi_cs_n_falling_in && !spi_cs_n_rising_in) begin
          state_d    = RECV;
          bit_cnt_d  = 3'd0;
          shift_d    = 7'd0;
          byte_cnt_d = '0;
          first_d    = 1'b1;
        end
      end
      RECV: begin
        if (spi_cs_n_rising_in) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          bit_cnt_d   = 3'd0;
          if (spi_sclk_rising_in && bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
          end else begin
            frame_err_d = (bit_cnt_q != 3'd0);
          end
        end else if (spi_cs_n_falling_in) begin
          frame_err_d = (bit_cnt_q != 3'd0);
          bit_cnt_d   = 3'd0;
          shift_d     = 7'd0;
          byte_cnt_d  = '0;
          first_d     = 1'b1;
        end else if (spi_sclk_rising_in) begin
          shift_d   = {shift_q[5:0], mosi_d};
          bit_cnt_d = bit_cnt_q + 3'd1;
          byte_done = (bit_cnt_q == 3'd7);
        end
      end
      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      byte_data_d  = {shift_q, mosi_d};
      byte_valid_d = 1'b1;
      byte_first_d = first_q;
      first_d      = 1'b0;
      if (byte_cnt_q != '1) begin
        byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      first_q      <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_valid_q <= 1'b0;
      byte_first_q <= 1'b0;
      byte_cnt_q   <= '0;
      frame_end_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      first_q      <= first_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      byte_first_q <= byte_first_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_end_q  <= frame_end_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid_out = byte_valid_q;
  assign byte_data_out  = byte_data_q;
  assign byte_first_out = byte_first_q;
  assign byte_cnt_out   = byte_cnt_q;
  assign frame_end_out  = frame_end_q;
  assign frame_err_out  = frame_err_q;

endmodule
